alu_gray_sequencer: RTL and testbench
=====================================

Name: alu_gray_sequencer

Overview:
- Sequencing stage that sits directly upstream of the Gray-operand ALU core and also captures its outputs.
- Accepts binary operands and an opcode on a start pulse, and converts the operands to Gray code.
- Drives the core's g1/g2/op inputs stably for a programmable settle window, then registers R, Zero and Overflow.
- Reports the registered result with a one-cycle done pulse and a sticky overflow flag; the combinational core then behaves as a clocked, handshaked functional unit.

Parameters:
- SETTLE_CYCLES, 4, number of clock edges g1/g2/op are held before core outputs are sampled; legal range 1..15. Sized for the core's worst ripple path against the target clock.
- CNT_W, 4, settle-counter width; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a_in  input  4  operand A, plain binary.
- b_in  input  4  operand B, plain binary.
- op_in  input  2  opcode passed to core unchanged.
- clr_sticky  input  1  clears ovf_sticky.
- g1  output  4  Gray-coded A to core (registered).
- g2  output  4  Gray-coded B to core (registered).
- op  output  2  opcode to core (registered).
- core_r  input  4  core R output.
- core_zero  input  1  core Zero output.
- core_ovf  input  1  core Overflow output.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse: result/zero/overflow newly valid.
- result  output  4  captured core_r.
- zero  output  1  captured core_zero.
- overflow  output  1  captured core_ovf.
- ovf_sticky  output  1  set by any captured overflow until cleared.
- op_count  output  8  completed operations, saturating at 255.

Behaviour:
- Reset (rst=1 at a clock edge), all registered, no asynchronous paths:
  - state=IDLE, counter=0.
  - g1, g2, op, result = 0; busy, done, zero, overflow, ovf_sticky = 0; op_count = 0.
- Reset mid-operation aborts the operation: no done pulse, no capture, and op_count is unchanged apart from being cleared.
- FSM states: IDLE, SETTLE.
- IDLE with start=1 at edge E0:
  - g1 <= a_in ^ (a_in>>1) and g2 <= b_in ^ (b_in>>1), i.e. g[3]=b[3], g[i]=b[i+1]^b[i].
  - op <= op_in; counter <= 0; busy <= 1; state <= SETTLE.
- IDLE with start=0: hold all outputs. done is forced to 0 on every edge except a capture edge.
- SETTLE, each edge: counter increments. g1/g2/op are held constant regardless of a_in/b_in/op_in/start.
- SETTLE capture edge, the edge at which counter==SETTLE_CYCLES-1, i.e. edge E0+SETTLE_CYCLES:
  - result <= core_r; zero <= core_zero; overflow <= core_ovf.
  - done <= 1; busy <= 0; state <= IDLE.
  - op_count <= op_count+1, saturating at 255 (no wrap).
- Latency: start edge to done-high = SETTLE_CYCLES edges. done stays high for exactly one cycle.
- start while busy=1 is ignored and not queued.
- Back-to-back: start=1 during the done cycle is accepted, since state is IDLE. The next issue occurs at edge E0+SETTLE_CYCLES+1.
- result/zero/overflow hold their last captured values until the next capture edge. They are never cleared except by reset.
- g1/g2/op keep their last driven values in IDLE; no return to zero.
- ovf_sticky:
  - Set at a capture edge with core_ovf=1.
  - Cleared at an edge with clr_sticky=1.
  - If both occur on the same edge, set wins (ovf_sticky=1).
  - clr_sticky is honoured in any state.
- SETTLE_CYCLES=1: capture occurs on the edge right after issue.

Test Plan:
- Reset, then start with a_in=4'b0110, b_in=4'b1011, op_in=2'b01 -> next cycle g1=4'b0101, g2=4'b1110, op=01, busy=1. With SETTLE_CYCLES=4, done=1 exactly 4 edges later, busy=0 in the same cycle.
- Stub core driving core_r=4'h9, core_zero=0, core_ovf=1 only at the capture edge, garbage otherwise -> result=9, zero=0, overflow=1, ovf_sticky=1, op_count=1. Values held through 10 idle cycles.
- start pulsed again, and a_in changed, 2 cycles into SETTLE -> g1 unchanged, only one done pulse, op_count increments by exactly 1.
- start held high continuously for 3 operations -> issue edges spaced SETTLE_CYCLES+1 apart, three single-cycle done pulses, op_count=3.
- Capture with core_ovf=1 on the same edge as clr_sticky=1 -> ovf_sticky=1. clr_sticky=1 on the next edge -> ovf_sticky=0.
- rst asserted 2 cycles into SETTLE -> next cycle all outputs 0, state IDLE, no done.
- Separately, run 256+ operations -> op_count saturates at 255.

Source files
------------

// File: rtl/alu_gray_sequencer.sv
// alu_gray_sequencer: wraps a combinational Gray-operand ALU core as a clocked
// functional unit. It latches binary operands on start and drives their Gray
// codes to the core. It holds them for SETTLE_CYCLES edges, then captures
// R/Zero/Overflow and issues a one-cycle done pulse.
module alu_gray_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       a_in,
  input  logic [3:0]       b_in,
  input  logic [1:0]       op_in,
  input  logic             clr_sticky,
  output logic [3:0]       g1,
  output logic [3:0]       g2,
  output logic [1:0]       op,
  input  logic [3:0]       core_r,
  input  logic             core_zero,
  input  logic             core_ovf,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result,
  output logic             zero,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic [7:0]       op_count
);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             capture;

  // Capture edge: last cycle of the settle window.
  always_comb begin
    capture = (state == SETTLE) && (counter == LAST_CNT);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      g1         <= '0;
      g2         <= '0;
      op         <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            g1      <= a_in ^ (a_in >> 1);
            g2      <= b_in ^ (b_in >> 1);
            op      <= op_in;
            counter <= '0;
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          counter <= counter + 1'b1;
          if (capture) begin
            result   <= core_r;
            zero     <= core_zero;
            overflow <= core_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
            if (op_count != 8'hFF) begin
              op_count <= op_count + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A new overflow on the capture edge takes priority over a clear.
      if (capture && core_ovf) begin
        ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_gray_sequencer.sv
// Testbench for alu_gray_sequencer: directed steps plus random traffic,
// checked every cycle against an operation-level reference model.
module tb_alu_gray_sequencer;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst, start, clr_sticky;
  logic [3:0] a_in, b_in;
  logic [1:0] op_in;
  logic [3:0] g1, g2;
  logic [1:0] op;
  logic [3:0] core_r;
  logic       core_zero, core_ovf;
  logic       busy, done, zero, overflow, ovf_sticky;
  logic [3:0] result;
  logic [7:0] op_count;

  alu_gray_sequencer #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .op_in(op_in), .clr_sticky(clr_sticky), .g1(g1), .g2(g2), .op(op),
    .core_r(core_r), .core_zero(core_zero), .core_ovf(core_ovf),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .ovf_sticky(ovf_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Gray code table, written out by value.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Reference model: one operation in flight, tracked by edges elapsed.
  logic [3:0] m_g1, m_g2, m_res;
  logic [1:0] m_op;
  logic       m_busy, m_done, m_zero, m_ovf, m_sticky;
  int         m_count, m_elapsed;

  // Stub core: fixed values at the capture edge when requested, garbage otherwise.
  logic       use_fixed = 1'b0;
  logic [3:0] fx_r = '0;
  logic       fx_z = 1'b0, fx_o = 1'b0;
  int         done_seen = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("g1", {4'h0, g1}, {4'h0, m_g1});
    chk("g2", {4'h0, g2}, {4'h0, m_g2});
    chk("op", {6'h0, op}, {6'h0, m_op});
    chk("busy", {7'h0, busy}, {7'h0, m_busy});
    chk("done", {7'h0, done}, {7'h0, m_done});
    chk("result", {4'h0, result}, {4'h0, m_res});
    chk("zero", {7'h0, zero}, {7'h0, m_zero});
    chk("overflow", {7'h0, overflow}, {7'h0, m_ovf});
    chk("ovf_sticky", {7'h0, ovf_sticky}, {7'h0, m_sticky});
    chk("op_count", op_count, m_count[7:0]);
  endtask

  task automatic step(input logic r, input logic s, input logic [3:0] a,
                      input logic [3:0] b, input logic [1:0] o, input logic clr);
    logic cap_next;
    logic cap;
    rst = r; start = s; a_in = a; b_in = b; op_in = o; clr_sticky = clr;
    cap_next = !r && m_busy && (m_elapsed == S - 1);
    if (cap_next && use_fixed) begin
      core_r = fx_r; core_zero = fx_z; core_ovf = fx_o;
    end else begin
      core_r = 4'($urandom); core_zero = 1'($urandom); core_ovf = 1'($urandom);
    end
    @(posedge clk);
    cap = 1'b0;
    if (r) begin
      m_g1 = '0; m_g2 = '0; m_op = '0; m_res = '0;
      m_busy = 0; m_done = 0; m_zero = 0; m_ovf = 0; m_sticky = 0;
      m_count = 0; m_elapsed = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_elapsed++;
        if (m_elapsed == S) begin
          cap = 1'b1;
          m_res = core_r; m_zero = core_zero; m_ovf = core_ovf;
          m_busy = 0; m_done = 1;
          if (m_count < 255) m_count++;
        end
      end else if (s) begin
        m_g1 = gray_tab[a]; m_g2 = gray_tab[b]; m_op = o;
        m_busy = 1; m_elapsed = 0;
      end
      if (cap && core_ovf) m_sticky = 1;
      else if (clr) m_sticky = 0;
    end
    #1;
    if (done === 1'b1) done_seen++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
  endtask

  initial begin
    int base;
    // Reset state
    step(1'b1, 1'b0, 4'h0, 4'h0, 2'h0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'hF, 2'h3, 1'b1);
    chk("rst_count", op_count, 8'h00);

    // First operation with known core outputs at the capture edge
    use_fixed = 1'b1; fx_r = 4'h9; fx_z = 1'b0; fx_o = 1'b1;
    step(1'b0, 1'b1, 4'b0110, 4'b1011, 2'b01, 1'b0);
    chk("issue_g1", {4'h0, g1}, 8'h05);
    chk("issue_g2", {4'h0, g2}, 8'h0E);
    chk("issue_busy", {7'h0, busy}, 8'h01);
    idle(S - 1);
    chk("pre_done", {7'h0, done}, 8'h00);
    idle(1);
    chk("lat_done", {7'h0, done}, 8'h01);
    chk("lat_busy", {7'h0, busy}, 8'h00);
    chk("cap_result", {4'h0, result}, 8'h09);
    chk("cap_sticky", {7'h0, ovf_sticky}, 8'h01);
    idle(10);
    chk("hold_result", {4'h0, result}, 8'h09);
    chk("hold_count", op_count, 8'h01);

    // start re-pulsed mid-settle with changed operands is ignored
    step(1'b0, 1'b1, 4'h3, 4'h4, 2'h2, 1'b0);
    idle(1);
    done_seen = 0;
    step(1'b0, 1'b1, 4'hC, 4'h1, 2'h1, 1'b0);
    chk("ignore_g1", {4'h0, g1}, 8'h02);
    idle(S + 4);
    chk("ignore_done_cnt", 8'(done_seen), 8'h01);
    chk("ignore_count", op_count, 8'h02);

    // start held for three back-to-back operations
    done_seen = 0;
    for (int i = 0; i < 3 * (S + 1); i++)
      step(1'b0, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
    idle(2);
    chk("b2b_done_cnt", 8'(done_seen), 8'h03);
    chk("b2b_count", op_count, 8'h05);

    // Overflow capture coincident with clr_sticky: set wins, then clear
    fx_o = 1'b1;
    step(1'b0, 1'b0, 4'h0, 4'h0, 2'h0, 1'b1);
    step(1'b0, 1'b1, 4'h7, 4'h2, 2'h0, 1'b0);
    idle(S - 1);
    step(1'b0, 1'b0, 4'h0, 4'h0, 2'h0, 1'b1);
    chk("clr_vs_set", {7'h0, ovf_sticky}, 8'h01);
    step(1'b0, 1'b0, 4'h0, 4'h0, 2'h0, 1'b1);
    chk("clr_after", {7'h0, ovf_sticky}, 8'h00);
    use_fixed = 1'b0;

    // Reset two cycles into settle aborts the operation
    step(1'b0, 1'b1, 4'h9, 4'h6, 2'h3, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 4'h0, 4'h0, 2'h0, 1'b0);
    chk("abort_busy", {7'h0, busy}, 8'h00);
    chk("abort_g1", {4'h0, g1}, 8'h00);
    done_seen = 0;
    idle(S + 2);
    chk("abort_no_done", 8'(done_seen), 8'h00);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
           2'($urandom), 1'($urandom_range(0, 9) == 0));

    // Saturation of op_count
    step(1'b1, 1'b0, 4'h0, 4'h0, 2'h0, 1'b0);
    base = 0;
    for (int i = 0; i < 260 * (S + 1); i++) begin
      step(1'b0, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
      base++;
    end
    idle(S + 1);
    chk("sat_count", op_count, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
